// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int MIN_PRESCALE      = 4;
   localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   // NOTE: clocked state uses non-blocking assignments so both flops sample the pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta     <= 1'b1;
         sync_out <= 1'b1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART Rx bit sampler: start qualification, per-bit timing, 3-sample majority vote and
// per-bit strobes for the deserializer, parity and stop stages.
module uart_rx_bit_sampler
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS      = DEFAULT_DATA_BITS,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          rx_in,
   input  logic [PRESCALE_WIDTH-1:0]     prescale,
   input  logic                          parity_en,
   output logic                          sampled_bit,
   output logic                          data_strobe,
   output logic [$clog2(DATA_BITS)-1:0]  bit_index,
   output logic                          par_strobe,
   output logic                          frame_done,
   output logic                          stop_error,
   output logic                          start_glitch,
   output logic                          busy
);

   localparam int IDX_W = $clog2(DATA_BITS);

   typedef logic [PRESCALE_WIDTH-1:0] cnt_t;
   typedef logic [IDX_W-1:0]          idx_t;

   localparam cnt_t ONE       = cnt_t'(1);
   localparam cnt_t P_MIN     = cnt_t'(MIN_PRESCALE);
   localparam idx_t LAST_IDX  = idx_t'(DATA_BITS - 1);

   logic      rx_s;
   rx_state_e state_q, state_d;
   cnt_t      edge_cnt_q, edge_cnt_d;
   cnt_t      p_q, p_d;
   logic      s0_q, s0_d, s1_q, s1_d;
   idx_t      bit_index_q, bit_index_d;
   logic      sampled_bit_q, sampled_bit_d;
   logic      data_strobe_q, data_strobe_d;
   logic      par_strobe_q, par_strobe_d;
   logic      frame_done_q, frame_done_d;
   logic      stop_error_q, stop_error_d;
   logic      start_glitch_q, start_glitch_d;
   logic      busy_q, busy_d;

   cnt_t      mid;
   logic      at_boundary;
   logic      vote_edge;
   logic      majority;

   uart_rx_sync u_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (rx_in),
      .sync_out (rx_s)
   );

   assign mid         = p_q >> 1;
   assign at_boundary = (edge_cnt_q == p_q - ONE);
   // The third sample is the live rx_s, so the vote registers on the edge ending count mid+1.
   assign vote_edge   = (edge_cnt_q == mid + ONE);
   assign majority    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         edge_cnt_q     <= '0;
         p_q            <= P_MIN;
         s0_q           <= 1'b1;
         s1_q           <= 1'b1;
         bit_index_q    <= '0;
         sampled_bit_q  <= 1'b1;
         data_strobe_q  <= 1'b0;
         par_strobe_q   <= 1'b0;
         frame_done_q   <= 1'b0;
         stop_error_q   <= 1'b0;
         start_glitch_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         edge_cnt_q     <= edge_cnt_d;
         p_q            <= p_d;
         s0_q           <= s0_d;
         s1_q           <= s1_d;
         bit_index_q    <= bit_index_d;
         sampled_bit_q  <= sampled_bit_d;
         data_strobe_q  <= data_strobe_d;
         par_strobe_q   <= par_strobe_d;
         frame_done_q   <= frame_done_d;
         stop_error_q   <= stop_error_d;
         start_glitch_q <= start_glitch_d;
         busy_q         <= busy_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output is defaulted first so no path can infer a latch.
      state_d        = state_q;
      edge_cnt_d     = edge_cnt_q;
      p_d            = p_q;
      s0_d           = s0_q;
      s1_d           = s1_q;
      bit_index_d    = bit_index_q;
      sampled_bit_d  = sampled_bit_q;
      data_strobe_d  = 1'b0;
      par_strobe_d   = 1'b0;
      frame_done_d   = 1'b0;
      stop_error_d   = 1'b0;
      start_glitch_d = 1'b0;
      busy_d         = busy_q;

      if (state_q != IDLE) begin
         edge_cnt_d = at_boundary ? '0 : edge_cnt_q + ONE;
         if (edge_cnt_q == mid - ONE) s0_d = rx_s;
         if (edge_cnt_q == mid)       s1_d = rx_s;
         if (vote_edge)               sampled_bit_d = majority;
      end

      case (state_q)
         IDLE: begin
            edge_cnt_d = '0;
            if (!rx_s) begin
               state_d    = START;
               edge_cnt_d = ONE;
               busy_d     = 1'b1;
               p_d        = (prescale < P_MIN) ? P_MIN : prescale;
            end
         end
         START: begin
            if (vote_edge && majority) begin
               start_glitch_d = 1'b1;
               busy_d         = 1'b0;
               state_d        = IDLE;
               edge_cnt_d     = '0;
            end else if (at_boundary) begin
               state_d     = DATA;
               bit_index_d = '0;
            end
         end
         DATA: begin
            if (vote_edge) data_strobe_d = 1'b1;
            if (at_boundary) begin
               if (bit_index_q == LAST_IDX) state_d = parity_en ? PARITY : STOP;
               else                         bit_index_d = bit_index_q + idx_t'(1);
            end
         end
         PARITY: begin
            if (vote_edge)   par_strobe_d = 1'b1;
            if (at_boundary) state_d = STOP;
         end
         STOP: begin
            // Return to IDLE half a bit early so a back-to-back start edge is not missed.
            if (vote_edge) begin
               frame_done_d = 1'b1;
               stop_error_d = ~majority;
               busy_d       = 1'b0;
               bit_index_d  = '0;
               edge_cnt_d   = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sampled_bit  = sampled_bit_q;
   assign data_strobe  = data_strobe_q;
   assign bit_index    = bit_index_q;
   assign par_strobe   = par_strobe_q;
   assign frame_done   = frame_done_q;
   assign stop_error   = stop_error_q;
   assign start_glitch = start_glitch_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler: expected strobes are queued as bits are driven and
// checked by a monitor thread when the DUT emits them.
module tb_uart_rx_bit_sampler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx_in = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       parity_en = 1'b0;
   logic       sampled_bit;
   logic       data_strobe;
   logic [2:0] bit_index;
   logic       par_strobe;
   logic       frame_done;
   logic       stop_error;
   logic       start_glitch;
   logic       busy;

   typedef enum logic [1:0] {EV_DATA, EV_PAR, EV_DONE, EV_GLITCH} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      logic     value;
      int       idx;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   uart_rx_bit_sampler #(.DATA_BITS(8), .PRESCALE_WIDTH(6)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_in        (rx_in),
      .prescale     (prescale),
      .parity_en    (parity_en),
      .sampled_bit  (sampled_bit),
      .data_strobe  (data_strobe),
      .bit_index    (bit_index),
      .par_strobe   (par_strobe),
      .frame_done   (frame_done),
      .stop_error   (stop_error),
      .start_glitch (start_glitch),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sampled_bit"},  32'(sampled_bit),  32'd1);
      check({tag, "_data_strobe"},  32'(data_strobe),  32'd0);
      check({tag, "_par_strobe"},   32'(par_strobe),   32'd0);
      check({tag, "_frame_done"},   32'(frame_done),   32'd0);
      check({tag, "_stop_error"},   32'(stop_error),   32'd0);
      check({tag, "_start_glitch"}, 32'(start_glitch), 32'd0);
      check({tag, "_busy"},         32'(busy),         32'd0);
      check({tag, "_bit_index"},    32'(bit_index),    32'd0);
   endtask

   task automatic monitor();
      int       n;
      ev_kind_e obs_kind;
      ev_t      e;
      forever begin
         @(negedge clock);
         n = $countones({data_strobe, par_strobe, frame_done, start_glitch});
         if (!reset && n != 0) begin
            check("strobe_onehot", 32'(n), 32'd1);
            obs_kind = data_strobe ? EV_DATA : par_strobe ? EV_PAR :
                       frame_done ? EV_DONE : EV_GLITCH;
            if (exp_q.size() == 0) begin
               check("unexpected_event", 32'(obs_kind) + 32'd100, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", 32'(obs_kind), 32'(e.kind));
               case (e.kind)
                  EV_DATA: begin
                     check("data_bit",  32'(sampled_bit), 32'(e.value));
                     check("bit_index", 32'(bit_index),   32'(e.idx));
                  end
                  EV_PAR:  check("parity_bit", 32'(sampled_bit), 32'(e.value));
                  EV_DONE: begin
                     check("stop_error",   32'(stop_error), 32'(e.value));
                     check("busy_at_done", 32'(busy),       32'd0);
                  end
                  default: check("busy_at_glitch", 32'(busy), 32'd0);
               endcase
            end
         end
      end
   endtask

   task automatic send_bit(input logic b, input int p, input bit noise);
      for (int i = 0; i < p; i++) begin
         rx_in = (noise && i == p / 2) ? ~b : b;
         @(negedge clock);
      end
   endtask

   // Drives one frame; busy must still be low two cycles after the start edge and high on the third.
   task automatic send_frame(input logic [7:0] data, input int p, input bit par,
                             input logic stop_val, input bit noise, input logic [5:0] mid_p);
      prescale  = 6'(p);
      parity_en = par;
      for (int i = 0; i < p; i++) begin
         rx_in = (noise && i == p / 2) ? 1'b1 : 1'b0;
         @(negedge clock);
         if (i == 1) check("busy_before_start", 32'(busy), 32'd0);
         if (i == 2) check("busy_after_start",  32'(busy), 32'd1);
      end
      prescale = mid_p;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back('{EV_DATA, data[i], i});
         send_bit(data[i], p, noise);
      end
      if (par) begin
         exp_q.push_back('{EV_PAR, ^data, 0});
         send_bit(^data, p, noise);
      end
      exp_q.push_back('{EV_DONE, ~stop_val, 0});
      if (!stop_val) exp_q.push_back('{EV_GLITCH, 1'b0, 0});
      send_bit(stop_val, p, noise);
      rx_in    = 1'b1;
      prescale = 6'(p);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   initial begin
      fork
         monitor();
      join_none

      reset = 1'b1;
      repeat (4) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      idle(4);

      // Basic frame, no parity.
      send_frame(8'hA5, 8, 1'b0, 1'b1, 1'b0, 6'd8);
      idle(16);

      // Parity frame; the prescale input changes mid-frame and must be ignored.
      send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 6'd5);
      parity_en = 1'b0;
      idle(32);

      // Two-clock low glitch on an idle line.
      prescale = 6'd8;
      exp_q.push_back('{EV_GLITCH, 1'b0, 0});
      rx_in = 1'b0;
      repeat (2) @(negedge clock);
      check("glitch_busy_pre", 32'(busy), 32'd0);
      rx_in = 1'b1;
      @(negedge clock);
      check("glitch_busy_rise", 32'(busy), 32'd1);
      idle(16);
      check("glitch_busy_done", 32'(busy), 32'd0);

      // Stop bit held low: stop error, then an immediate restart that the vote rejects.
      send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 6'd8);
      idle(32);
      check("break_busy_done", 32'(busy), 32'd0);

      // Back-to-back frames; the second start must be caught right after the first stop.
      send_frame(8'h12, 8, 1'b0, 1'b1, 1'b0, 6'd8);
      send_frame(8'hED, 8, 1'b0, 1'b1, 1'b0, 6'd8);
      idle(16);

      // One inverted mid-bit sample per bit must be outvoted.
      send_frame(8'h55, 16, 1'b0, 1'b1, 1'b1, 6'd16);
      idle(32);

      // Reset in the middle of data bit 3, then a clean frame.
      prescale = 6'd8;
      send_bit(1'b0, 8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{EV_DATA, 1'(8'hA5 >> i), i});
         send_bit(1'(8'hA5 >> i), 8, 1'b0);
      end
      send_bit(1'b0, 4, 1'b0);
      check("mid_bit_index", 32'(bit_index), 32'd3);
      check("mid_busy",      32'(busy),      32'd1);
      reset = 1'b1;
      rx_in = 1'b1;
      @(negedge clock);
      check_reset_outputs("midreset");
      reset = 1'b0;
      idle(24);
      send_frame(8'h96, 8, 1'b0, 1'b1, 1'b0, 6'd8);
      idle(24);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
